// File: rtl/mmcm_drp_pkg.sv
// Shared types and widths for the MMCM DRP configuration controller.
package mmcm_drp_pkg;

    localparam int DRP_AW = 7;
    localparam int DRP_DW = 16;
    localparam int CFG_DW = 32;
    localparam int TMR_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_ON,
        ST_ISSUE,
        ST_WAIT_DRDY,
        ST_HOLD,
        ST_WAIT_LOCK
    } state_e;

    typedef struct packed {
        logic              wen;
        logic [DRP_AW-1:0] addr;
        logic [DRP_DW-1:0] wdata;
    } req_t;

    // Counter load value: 0 behaves as 1, values beyond the counter saturate.
    function automatic logic [TMR_W-1:0] tmr_load(input int unsigned v);
        logic [TMR_W-1:0] r;
        if (v == 0)
            r = 1;
        else if (v > 32'(2 ** TMR_W - 1))
            r = '1;
        else
            r = v[TMR_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/drp_timer.sv
// Load/decrement counter shared by the DRP, reset-hold and lock-wait phases.
module drp_timer
    import mmcm_drp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             expired_o
);

    localparam logic [TMR_W-1:0] ONE = TMR_W'(1);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - ONE;
    end

    // NOTE: clocked state uses <= only, so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // A load of N gives N phase cycles; the last one reports expiry.
    assign expired_o = (cnt_q <= ONE);

endmodule

// File: rtl/mmcm_drp_ctrl.sv
// Runs single-outstanding cfg requests on the MMCM DRP port, wrapping writes
// in an MMCM reset window and waiting for LOCKED afterwards.
module mmcm_drp_ctrl
    import mmcm_drp_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned DRP_TIMEOUT     = 255,
    parameter int unsigned LOCK_TIMEOUT    = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_ena,
    input  logic              cfg_wen,
    input  logic [DRP_AW-1:0] cfg_addr,
    input  logic [CFG_DW-1:0] cfg_wdata,
    output logic [CFG_DW-1:0] cfg_rdata,
    output logic              cfg_rdy,
    output logic              drp_den,
    output logic              drp_dwe,
    output logic [DRP_AW-1:0] drp_daddr,
    output logic [DRP_DW-1:0] drp_di,
    input  logic [DRP_DW-1:0] drp_do,
    input  logic              drp_drdy,
    output logic              mmcm_rst,
    input  logic              mmcm_locked,
    output logic              busy,
    output logic              drp_err,
    output logic              lock_err,
    output logic              req_ovf
);

    localparam logic [TMR_W-1:0] DRP_LD  = tmr_load(DRP_TIMEOUT);
    localparam logic [TMR_W-1:0] HOLD_LD = tmr_load(RST_HOLD_CYCLES);
    localparam logic [TMR_W-1:0] LOCK_LD = tmr_load(LOCK_TIMEOUT);

    state_e            state_q, state_d;
    req_t              slot_q, slot_d;
    logic              slot_full_q, slot_full_d;
    logic              cur_wen_q, cur_wen_d;
    logic [CFG_DW-1:0] cfg_rdata_q, cfg_rdata_d;
    logic              cfg_rdy_q, cfg_rdy_d;
    logic              drp_den_q, drp_den_d;
    logic              drp_dwe_q, drp_dwe_d;
    logic [DRP_AW-1:0] drp_daddr_q, drp_daddr_d;
    logic [DRP_DW-1:0] drp_di_q, drp_di_d;
    logic              mmcm_rst_q, mmcm_rst_d;
    logic              busy_q, busy_d;
    logic              drp_err_q, drp_err_d;
    logic              lock_err_q, lock_err_d;
    logic              req_ovf_q, req_ovf_d;

    logic              tmr_load_en;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired;
    logic              wdata_hi_unused;

    assign wdata_hi_unused = ^cfg_wdata[CFG_DW-1:DRP_DW];

    drp_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_en),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can infer a latch.
        state_d     = state_q;
        slot_d      = slot_q;
        slot_full_d = slot_full_q;
        cur_wen_d   = cur_wen_q;
        cfg_rdata_d = cfg_rdata_q;
        cfg_rdy_d   = 1'b0;
        drp_den_d   = 1'b0;
        drp_dwe_d   = 1'b0;
        drp_daddr_d = drp_daddr_q;
        drp_di_d    = drp_di_q;
        mmcm_rst_d  = mmcm_rst_q;
        drp_err_d   = drp_err_q;
        lock_err_d  = lock_err_q;
        req_ovf_d   = req_ovf_q;

        // The slot frees in ISSUE, so a request landing that same cycle is kept.
        if (state_q == ST_ISSUE) begin
            slot_full_d = 1'b0;
            cur_wen_d   = slot_q.wen;
        end
        if (cfg_ena) begin
            if (slot_full_q && state_q != ST_ISSUE) begin
                req_ovf_d = 1'b1;
            end else begin
                slot_full_d = 1'b1;
                slot_d      = '{wen: cfg_wen, addr: cfg_addr, wdata: cfg_wdata[DRP_DW-1:0]};
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (slot_full_q) begin
                    if (slot_q.wen) begin
                        state_d    = ST_RST_ON;
                        mmcm_rst_d = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_RST_ON: state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_WAIT_DRDY;
            ST_WAIT_DRDY: begin
                // drdy wins over a timeout expiring in the same cycle.
                if (drp_drdy || tmr_expired) begin
                    cfg_rdy_d = 1'b1;
                    state_d   = mmcm_rst_q ? ST_HOLD : ST_IDLE;
                    if (drp_drdy && !cur_wen_q)
                        cfg_rdata_d = {{(CFG_DW-DRP_DW){1'b0}}, drp_do};
                    else
                        cfg_rdata_d = '0;
                    if (!drp_drdy)
                        drp_err_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (slot_full_q) begin
                    state_d = ST_ISSUE;
                end else if (tmr_expired) begin
                    state_d    = ST_WAIT_LOCK;
                    mmcm_rst_d = 1'b0;
                end
            end
            ST_WAIT_LOCK: begin
                if (mmcm_locked) begin
                    state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    state_d    = ST_IDLE;
                    lock_err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ISSUE) begin
            drp_den_d   = 1'b1;
            drp_dwe_d   = slot_q.wen;
            drp_daddr_d = slot_q.addr;
            drp_di_d    = slot_q.wdata;
        end
        busy_d = (state_d != ST_IDLE);

        tmr_load_en = (state_d != state_q);
        case (state_d)
            ST_WAIT_DRDY: tmr_val = DRP_LD;
            ST_HOLD:      tmr_val = HOLD_LD;
            ST_WAIT_LOCK: tmr_val = LOCK_LD;
            default:      tmr_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the slot and data registers are reset too, so every output reads 0 out of reset.
        if (rst) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            slot_full_q <= 1'b0;
            cur_wen_q   <= 1'b0;
            cfg_rdata_q <= '0;
            cfg_rdy_q   <= 1'b0;
            drp_den_q   <= 1'b0;
            drp_dwe_q   <= 1'b0;
            drp_daddr_q <= '0;
            drp_di_q    <= '0;
            mmcm_rst_q  <= 1'b0;
            busy_q      <= 1'b0;
            drp_err_q   <= 1'b0;
            lock_err_q  <= 1'b0;
            req_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            slot_full_q <= slot_full_d;
            cur_wen_q   <= cur_wen_d;
            cfg_rdata_q <= cfg_rdata_d;
            cfg_rdy_q   <= cfg_rdy_d;
            drp_den_q   <= drp_den_d;
            drp_dwe_q   <= drp_dwe_d;
            drp_daddr_q <= drp_daddr_d;
            drp_di_q    <= drp_di_d;
            mmcm_rst_q  <= mmcm_rst_d;
            busy_q      <= busy_d;
            drp_err_q   <= drp_err_d;
            lock_err_q  <= lock_err_d;
            req_ovf_q   <= req_ovf_d;
        end
    end

    assign cfg_rdata = cfg_rdata_q;
    assign cfg_rdy   = cfg_rdy_q;
    assign drp_den   = drp_den_q;
    assign drp_dwe   = drp_dwe_q;
    assign drp_daddr = drp_daddr_q;
    assign drp_di    = drp_di_q;
    assign mmcm_rst  = mmcm_rst_q;
    assign busy      = busy_q;
    assign drp_err   = drp_err_q;
    assign lock_err  = lock_err_q;
    assign req_ovf   = req_ovf_q;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Scoreboard bench for mmcm_drp_ctrl: DRP accesses and cfg responses are
// predicted into queues and checked by independent monitors.
module tb_mmcm_drp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_ena = 1'b0;
    logic        cfg_wen = 1'b0;
    logic [6:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        cfg_rdy;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic        mmcm_rst;
    logic        mmcm_locked = 1'b0;
    logic        busy;
    logic        drp_err;
    logic        lock_err;
    logic        req_ovf;

    mmcm_drp_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_ena     (cfg_ena),
        .cfg_wen     (cfg_wen),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .cfg_rdy     (cfg_rdy),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_daddr   (drp_daddr),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .drp_drdy    (drp_drdy),
        .mmcm_rst    (mmcm_rst),
        .mmcm_locked (mmcm_locked),
        .busy        (busy),
        .drp_err     (drp_err),
        .lock_err    (lock_err),
        .req_ovf     (req_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; int cyc; } rsp_t;
    typedef struct { logic dwe; logic [6:0] addr; logic [15:0] di; int cyc; } acc_t;
    rsp_t rsp_q[$];
    acc_t acc_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic exp_acc(input logic dwe, input logic [6:0] addr, input logic [15:0] di, input int c);
        acc_t a;
        a.dwe = dwe; a.addr = addr; a.di = di; a.cyc = c;
        acc_q.push_back(a);
    endtask

    task automatic exp_rsp(input logic [31:0] rdata, input int c);
        rsp_t r;
        r.rdata = rdata; r.cyc = c;
        rsp_q.push_back(r);
    endtask

    // Response monitor.
    always @(negedge clk) begin
        rsp_t e;
        if (cfg_rdy) begin
            if (rsp_q.size() == 0) begin
                check("rdy_unexpected", 32'd1, 32'd0);
            end else begin
                e = rsp_q.pop_front();
                check("rdata", cfg_rdata, e.rdata);
                check("rdy_cycle", cyc, e.cyc);
            end
        end
    end

    // DRP slave model and access monitor; drp_delay 0 means never respond.
    int drp_delay = 3;
    int drdy_cnt  = 0;
    logic [15:0] model_do = '0;
    always @(negedge clk) begin
        acc_t a;
        drp_drdy = 1'b0;
        if (drdy_cnt > 0) begin
            drdy_cnt--;
            if (drdy_cnt == 0) begin
                drp_drdy = 1'b1;
                drp_do   = model_do;
            end
        end
        if (drp_den) begin
            if (drp_delay > 0) drdy_cnt = drp_delay;
            if (acc_q.size() == 0) begin
                check("den_unexpected", 32'd1, 32'd0);
            end else begin
                a = acc_q.pop_front();
                check("daddr", 32'(drp_daddr), 32'(a.addr));
                check("dwe", 32'(drp_dwe), 32'(a.dwe));
                if (a.dwe) check("di", 32'(drp_di), 32'(a.di));
                check("den_cycle", cyc, a.cyc);
            end
        end
    end

    // mmcm_rst / busy edge tracking and MMCM lock model; lock_delay -1 means never lock.
    int lock_delay    = -1;
    int rise_cnt      = 0;
    int rise_cyc      = -100000;
    int fall_cyc      = -100000;
    int busy_fall_cyc = -100000;
    logic mrst_prev = 1'b0;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (mmcm_rst && !mrst_prev) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        if (!mmcm_rst && mrst_prev) fall_cyc = cyc;
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        mrst_prev = mmcm_rst;
        busy_prev = busy;
        if (mmcm_rst)
            mmcm_locked = 1'b0;
        else if (!mmcm_locked && lock_delay >= 0 && cyc == fall_cyc + lock_delay)
            mmcm_locked = 1'b1;
    end

    task automatic issue(input logic wen, input logic [6:0] addr, input logic [31:0] wdata);
        cfg_ena   = 1'b1;
        cfg_wen   = wen;
        cfg_addr  = addr;
        cfg_wdata = wdata;
        @(negedge clk);
        cfg_ena   = 1'b0;
        cfg_wen   = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((rsp_q.size() != 0 || acc_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(rsp_q.size() + acc_q.size()), 32'd0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_rdy(input string name, input int budget);
        int n = 0;
        while (!cfg_rdy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_rdy_seen"}, 32'(cfg_rdy), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required end before it", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cfg_rdy", 32'(cfg_rdy), 32'd0);
        check("rst_cfg_rdata", cfg_rdata, 32'd0);
        check("rst_den", 32'(drp_den), 32'd0);
        check("rst_dwe", 32'(drp_dwe), 32'd0);
        check("rst_daddr", 32'(drp_daddr), 32'd0);
        check("rst_di", 32'(drp_di), 32'd0);
        check("rst_mmcm_rst", 32'(mmcm_rst), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drp_err", 32'(drp_err), 32'd0);
        check("rst_lock_err", 32'(lock_err), 32'd0);
        check("rst_req_ovf", 32'(req_ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read 0x14, drdy 3 cycles after den
        drp_delay = 3;
        model_do  = 16'h1041;
        n = cyc;
        exp_acc(1'b0, 7'h14, 16'h0, n + 2);
        exp_rsp(32'h0000_1041, n + 6);
        issue(1'b0, 7'h14, 32'h0);
        drain("rd", 50);
        wait_idle("rd", 50);
        check("rd_no_mmcm_rst", 32'(rise_cnt), 32'd0);

        // Write 0x08 = 0x00C3, lock 10 cycles after reset release
        lock_delay = 10;
        n = cyc;
        exp_acc(1'b1, 7'h08, 16'h00C3, n + 3);
        exp_rsp(32'h0, n + 7);
        issue(1'b1, 7'h08, 32'h0000_00C3);
        drain("wr", 50);
        wait_idle("wr", 100);
        check("wr_rst_rise", rise_cyc, n + 2);
        check("wr_rst_fall", fall_cyc, n + 23);
        check("wr_busy_fall", busy_fall_cyc, n + 34);
        check("wr_rst_pulses", 32'(rise_cnt), 32'd1);

        // Three back-to-back writes, each issued on the previous cfg_rdy
        n = cyc;
        exp_acc(1'b1, 7'h09, 16'hA5A5, n + 3);
        exp_rsp(32'h0, n + 7);
        exp_acc(1'b1, 7'h0A, 16'h5A5A, n + 9);
        exp_rsp(32'h0, n + 13);
        exp_acc(1'b1, 7'h0B, 16'h0001, n + 15);
        exp_rsp(32'h0, n + 19);
        issue(1'b1, 7'h09, 32'hDEAD_A5A5);
        wait_rdy("b2b1", 50);
        issue(1'b1, 7'h0A, 32'h0000_5A5A);
        wait_rdy("b2b2", 50);
        issue(1'b1, 7'h0B, 32'hFFFF_0001);
        drain("b2b", 50);
        wait_idle("b2b", 100);
        check("b2b_rst_pulses", 32'(rise_cnt), 32'd2);
        check("b2b_rst_rise", rise_cyc, n + 2);
        check("b2b_rst_fall", fall_cyc, n + 35);
        check("b2b_busy_fall", busy_fall_cyc, n + 46);

        // DRP never answers: timeout after 256 cycles
        drp_delay = 0;
        n = cyc;
        exp_acc(1'b0, 7'h20, 16'h0, n + 2);
        exp_rsp(32'h0, n + 258);
        issue(1'b0, 7'h20, 32'h0);
        drain("tmo", 300);
        check("tmo_drp_err", 32'(drp_err), 32'd1);
        check("tmo_lock_err", 32'(lock_err), 32'd0);

        // Following reads succeed; second request lands in the ISSUE cycle
        drp_delay = 2;
        model_do  = 16'hBEEF;
        n = cyc;
        exp_acc(1'b0, 7'h21, 16'h0, n + 2);
        exp_rsp(32'h0000_BEEF, n + 5);
        exp_acc(1'b0, 7'h22, 16'h0, n + 6);
        exp_rsp(32'h0000_BEEF, n + 9);
        issue(1'b0, 7'h21, 32'h0);
        @(negedge clk);
        issue(1'b0, 7'h22, 32'h0);
        drain("issue_cap", 50);
        check("issue_cap_no_ovf", 32'(req_ovf), 32'd0);
        check("issue_cap_drp_err_sticky", 32'(drp_err), 32'd1);

        // Two requests during a stalled access: one queued, one dropped
        drp_delay = 20;
        model_do  = 16'h0777;
        n = cyc;
        exp_acc(1'b0, 7'h30, 16'h0, n + 2);
        exp_rsp(32'h0000_0777, n + 23);
        exp_acc(1'b0, 7'h31, 16'h0, n + 24);
        exp_rsp(32'h0000_0777, n + 45);
        issue(1'b0, 7'h30, 32'h0);
        repeat (4) @(negedge clk);
        issue(1'b0, 7'h31, 32'h0);
        @(negedge clk);
        issue(1'b0, 7'h32, 32'h0);
        drain("ovf", 100);
        check("ovf_req_ovf", 32'(req_ovf), 32'd1);

        // rst asserted mid-HOLD
        drp_delay  = 3;
        lock_delay = 10;
        n = cyc;
        exp_acc(1'b1, 7'h0D, 16'h1234, n + 3);
        exp_rsp(32'h0, n + 7);
        issue(1'b1, 7'h0D, 32'h0000_1234);
        drain("hold", 50);
        m = 0;
        while (cyc < n + 12 && m < 50) begin
            @(negedge clk);
            m++;
        end
        check("hold_mmcm_rst", 32'(mmcm_rst), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("hold_rst_mmcm_rst", 32'(mmcm_rst), 32'd0);
        check("hold_rst_busy", 32'(busy), 32'd0);
        check("hold_rst_drp_err", 32'(drp_err), 32'd0);
        check("hold_rst_req_ovf", 32'(req_ovf), 32'd0);
        check("hold_rst_lock_err", 32'(lock_err), 32'd0);
        repeat (2) @(negedge clk);

        // Write with LOCKED never asserting: lock timeout
        lock_delay = -1;
        n = cyc;
        exp_acc(1'b1, 7'h0C, 16'h0042, n + 3);
        exp_rsp(32'h0, n + 7);
        issue(1'b1, 7'h0C, 32'h0000_0042);
        drain("lk", 50);
        m = 0;
        while (!lock_err && m < 70000) begin
            @(negedge clk);
            m++;
        end
        check("lk_err_cycle", cyc, n + 65558);
        check("lk_lock_err", 32'(lock_err), 32'd1);
        check("lk_mmcm_rst", 32'(mmcm_rst), 32'd0);
        check("lk_busy", 32'(busy), 32'd0);
        check("lk_drp_err", 32'(drp_err), 32'd0);
        @(negedge clk);
        check("lk_rst_fall", fall_cyc, n + 23);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
